// File: rtl/cordic_circ_engine.sv
// -----------------------------------------------------------------------------
// cordic_circ_engine
//   Iterative circular CORDIC engine, signed fixed point Q(WIDTH-FRAC).FRAC.
//   Rotation mode (mode=0) drives z to zero and produces cos/sin of z_in.
//   Vectoring mode (mode=1) drives y to zero and produces magnitude and atan2.
//   A quadrant pre-rotation extends the range to the full circle. Optional
//   gain compensation is applied in the POST cycle. Outputs are saturated.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous, active-low reset
//   enable  in   1      start request, sampled while idle
//   mode    in   1      0 = rotation, 1 = vectoring
//   x_in    in   WIDTH  initial x
//   y_in    in   WIDTH  initial y
//   z_in    in   WIDTH  initial angle (radians), range [-pi, +pi]
//   x_out   out  WIDTH  final x, saturated
//   y_out   out  WIDTH  final y, saturated
//   z_out   out  WIDTH  final angle, saturated
//   busy    out  1      high from accept through the POST cycle
//   done    out  1      one-cycle pulse when results are updated
// -----------------------------------------------------------------------------
module cordic_circ_engine #(
    parameter int WIDTH      = 32,
    parameter int FRAC       = 16,
    parameter int ITERATIONS = 16,
    parameter int GAIN_COMP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             busy,
    output logic             done
);

    // Internal datapath carries two guard bits above WIDTH.
    localparam int IW = WIDTH + 2;
    // Gain-compensation product width.
    localparam int PW = 2 * WIDTH + 4;
    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PREROT = 2'd1;
    localparam logic [1:0] S_ITER   = 2'd2;
    localparam logic [1:0] S_POST   = 2'd3;

    // atan(2^-i) in radians. Beyond the listed entries a short Taylor series
    // is exact to well below one LSB of any practical FRAC.
    function automatic real atan_pow2(input int unsigned i);
        real t;
        case (i)
            0:  atan_pow2 = 0.7853981633974483;
            1:  atan_pow2 = 0.4636476090008061;
            2:  atan_pow2 = 0.24497866312686414;
            3:  atan_pow2 = 0.12435499454676144;
            4:  atan_pow2 = 0.06241880999595735;
            5:  atan_pow2 = 0.031239833430268277;
            6:  atan_pow2 = 0.015623728620476831;
            7:  atan_pow2 = 0.007812341060101111;
            8:  atan_pow2 = 0.0039062301319669718;
            9:  atan_pow2 = 0.0019531225164788188;
            10: atan_pow2 = 0.0009765621895593195;
            11: atan_pow2 = 0.0004882812111948983;
            12: atan_pow2 = 0.00024414062014936177;
            13: atan_pow2 = 0.00012207031189367021;
            default: begin
                t = 1.0;
                for (int unsigned k = 0; k < i; k++) t = t / 2.0;
                atan_pow2 = t - (t * t * t) / 3.0 + (t * t * t * t * t) / 5.0;
            end
        endcase
    endfunction

    // round(r * 2^FRAC)
    function automatic longint to_fixed(input real r);
        real scale;
        scale = 1.0;
        for (int unsigned k = 0; k < int'(FRAC); k++) scale = scale * 2.0;
        return longint'($floor(r * scale + 0.5));
    endfunction

    localparam logic signed [IW-1:0] HALF_PI     = IW'(to_fixed(1.5707963267948966));
    localparam logic signed [IW-1:0] NEG_HALF_PI = -HALF_PI;
    localparam logic signed [PW-1:0] KQ          = PW'(to_fixed(0.6072529350));

    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [IW-1:0] atan_tab [ITERATIONS];

    for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
        localparam logic signed [IW-1:0] ATAN_G = IW'(to_fixed(atan_pow2(g)));
        assign atan_tab[g] = ATAN_G;
    end

    function automatic logic [WIDTH-1:0] saturate(input logic signed [PW-1:0] v);
        if (v > SAT_MAX)
            saturate = {1'b0, {(WIDTH-1){1'b1}}};
        else if (v < SAT_MIN)
            saturate = {1'b1, {(WIDTH-1){1'b0}}};
        else
            saturate = v[WIDTH-1:0];
    endfunction

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic                 mode_r;
    logic signed [IW-1:0] x_r, y_r, z_r;

    logic signed [IW-1:0] pre_x, pre_y, pre_z;
    logic signed [IW-1:0] it_x, it_y, it_z;
    logic signed [IW-1:0] xs, ys;
    logic                 d_pos;
    logic signed [PW-1:0] x_ext, y_ext, z_ext;
    logic signed [PW-1:0] px, py;
    logic signed [PW-1:0] gx, gy;
    logic [WIDTH-1:0]     post_x, post_y, post_z;

    assign busy = (state != S_IDLE);

    // Quadrant pre-rotation by +/- pi/2.
    always_comb begin
        pre_x = x_r;
        pre_y = y_r;
        pre_z = z_r;
        if (!mode_r) begin
            if (z_r > HALF_PI) begin
                pre_x = -y_r;
                pre_y = x_r;
                pre_z = z_r - HALF_PI;
            end else if (z_r < NEG_HALF_PI) begin
                pre_x = y_r;
                pre_y = -x_r;
                pre_z = z_r + HALF_PI;
            end
        end else if (x_r[IW-1]) begin
            if (!y_r[IW-1]) begin
                pre_x = y_r;
                pre_y = -x_r;
                pre_z = z_r + HALF_PI;
            end else begin
                pre_x = -y_r;
                pre_y = x_r;
                pre_z = z_r - HALF_PI;
            end
        end
    end

    // One micro-rotation; both updates use the pre-step x/y.
    always_comb begin
        d_pos = mode_r ? y_r[IW-1] : ~z_r[IW-1];
        xs    = x_r >>> cnt;
        ys    = y_r >>> cnt;
        if (d_pos) begin
            it_x = x_r - ys;
            it_y = y_r + xs;
            it_z = z_r - atan_tab[cnt];
        end else begin
            it_x = x_r + ys;
            it_y = y_r - xs;
            it_z = z_r + atan_tab[cnt];
        end
    end

    // Gain compensation and saturation.
    always_comb begin
        x_ext = {{(PW-IW){x_r[IW-1]}}, x_r};
        y_ext = {{(PW-IW){y_r[IW-1]}}, y_r};
        z_ext = {{(PW-IW){z_r[IW-1]}}, z_r};
        px    = x_ext * KQ;
        py    = y_ext * KQ;
        if (GAIN_COMP != 0) begin
            gx = px >>> FRAC;
            gy = py >>> FRAC;
        end else begin
            gx = x_ext;
            gy = y_ext;
        end
        post_x = saturate(gx);
        post_y = saturate(gy);
        post_z = saturate(z_ext);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mode_r <= 1'b0;
            x_r    <= '0;
            y_r    <= '0;
            z_r    <= '0;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        x_r    <= {{2{x_in[WIDTH-1]}}, x_in};
                        y_r    <= {{2{y_in[WIDTH-1]}}, y_in};
                        z_r    <= {{2{z_in[WIDTH-1]}}, z_in};
                        mode_r <= mode;
                        state  <= S_PREROT;
                    end
                end
                S_PREROT: begin
                    x_r   <= pre_x;
                    y_r   <= pre_y;
                    z_r   <= pre_z;
                    cnt   <= '0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    x_r <= it_x;
                    y_r <= it_y;
                    z_r <= it_z;
                    if (cnt == CW'(ITERATIONS - 1))
                        state <= S_POST;
                    else
                        cnt <= cnt + CW'(1);
                end
                S_POST: begin
                    x_out <= post_x;
                    y_out <= post_y;
                    z_out <= post_z;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_circ_engine.sv
// -----------------------------------------------------------------------------
// tb_cordic_circ_engine
//   Directed vectors with hand-computed expectations. The stimulus process
//   pushes the expected response when a job is issued; a monitor pops and
//   compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_cordic_circ_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] x_in = '0;
    logic [31:0] y_in = '0;
    logic [31:0] z_in = '0;
    logic [31:0] x_out, y_out, z_out;
    logic        busy, done;

    always #5 clk = ~clk;

    cordic_circ_engine #(
        .WIDTH(32),
        .FRAC(16),
        .ITERATIONS(16),
        .GAIN_COMP(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .mode(mode),
        .x_in(x_in),
        .y_in(y_in),
        .z_in(z_in),
        .x_out(x_out),
        .y_out(y_out),
        .z_out(z_out),
        .busy(busy),
        .done(done)
    );

    typedef struct {
        string       name;
        logic [31:0] ex, ey, ez;
        int          tx, ty, tz;   // tolerance in LSB, -1 = not checked
        longint      acc;          // cycle of the accepting edge
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_tol(input string nm, input logic [31:0] act,
                             input logic [31:0] expv, input int tol);
        longint diff;
        checks++;
        diff = longint'($signed(act)) - longint'($signed(expv));
        if (diff < 0) diff = -diff;
        if (diff > longint'(tol)) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h +/- %0d", nm, act, expv, tol);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, want no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.tx >= 0) check_tol({mon_e.name, ".x"}, x_out, mon_e.ex, mon_e.tx);
                if (mon_e.ty >= 0) check_tol({mon_e.name, ".y"}, y_out, mon_e.ey, mon_e.ty);
                if (mon_e.tz >= 0) check_tol({mon_e.name, ".z"}, z_out, mon_e.ez, mon_e.tz);
                checks++;
                if (cyc - mon_e.acc != 18) begin
                    errors++;
                    $display("FAIL %s.latency: got %0d cycles, want 18", mon_e.name, cyc - mon_e.acc);
                end
            end
        end
    end

    // Called right after a negedge; holds enable for exactly one posedge.
    task automatic issue(input string nm, input logic m,
                         input logic [31:0] xi, input logic [31:0] yi, input logic [31:0] zi,
                         input bit push,
                         input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ez,
                         input int tx, input int ty, input int tz);
        exp_t e;
        mode   = m;
        x_in   = xi;
        y_in   = yi;
        z_in   = zi;
        enable = 1'b1;
        if (push) begin
            e.name = nm;
            e.ex = ex; e.ey = ey; e.ez = ez;
            e.tx = tx; e.ty = ty; e.tz = tz;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s.timeout: got %0d pending results, want 0", nm, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check_tol("reset.x_out", x_out, 32'h0, 0);
        check_tol("reset.y_out", y_out, 32'h0, 0);
        check_tol("reset.z_out", z_out, 32'h0, 0);
        check_tol("reset.busy", {31'b0, busy}, 32'h0, 0);
        check_tol("reset.done", {31'b0, done}, 32'h0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Rotation pi/6
        issue("rot_pi6", 1'b0, 32'h0001_0000, 32'h0, 32'h0000_860A, 1'b1,
              32'h0000_DDB4, 32'h0000_8000, 32'h0, 8, 8, 8);
        check_tol("rot_pi6.busy", {31'b0, busy}, 32'h1, 0);
        wait_drain("rot_pi6");

        // Vectoring (1,1)
        issue("vec_45", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1,
              32'h0001_6A0A, 32'h0, 32'h0000_C910, 8, 8, 8);
        wait_drain("vec_45");

        // Vectoring (-1,1): second quadrant
        issue("vec_q2", 1'b1, 32'hFFFF_0000, 32'h0001_0000, 32'h0, 1'b1,
              32'h0001_6A0A, 32'h0, 32'h0002_5B2F, 8, 8, 8);
        wait_drain("vec_q2");

        // Vectoring (-1,-1): third quadrant
        issue("vec_q3", 1'b1, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0, 1'b1,
              32'h0001_6A0A, 32'h0, 32'hFFFD_A4D0, 8, 8, 8);
        wait_drain("vec_q3");

        // Rotation by +pi
        issue("rot_pi", 1'b0, 32'h0001_0000, 32'h0, 32'h0003_243F, 1'b1,
              32'hFFFF_0000, 32'h0, 32'h0, 8, 8, 8);
        wait_drain("rot_pi");

        // Rotation by -2pi/3: cos=-0.5, sin=-0.8660
        issue("rot_m120", 1'b0, 32'h0001_0000, 32'h0, 32'hFFFD_E7D6, 1'b1,
              32'hFFFF_8000, 32'hFFFF_224C, 32'h0, 8, 8, 8);
        wait_drain("rot_m120");

        // Saturation of magnitude
        issue("vec_sat", 1'b1, 32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 1'b1,
              32'h7FFF_FFFF, 32'h0, 32'h0000_C910, 0, -1, 8);
        wait_drain("vec_sat");

        // Handshake: mid-job request ignored, request in the done cycle accepted
        issue("hs_a", 1'b0, 32'h0001_0000, 32'h0, 32'h0000_860A, 1'b1,
              32'h0000_DDB4, 32'h0000_8000, 32'h0, 8, 8, 8);
        repeat (3) @(negedge clk);
        issue("hs_ignored", 1'b1, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0, 1'b0,
              32'h0, 32'h0, 32'h0, -1, -1, -1);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL hs.done_wait: got done=0, want done=1 within 40 cycles");
        end
        issue("hs_b", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1,
              32'h0001_6A0A, 32'h0, 32'h0000_C910, 8, 8, 8);
        wait_drain("hs_b");
        repeat (25) @(negedge clk);

        // Reset in the middle of the iterations
        issue("rst_job", 1'b0, 32'h0001_0000, 32'h0, 32'h0000_860A, 1'b0,
              32'h0, 32'h0, 32'h0, -1, -1, -1);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check_tol("midrst.x_out", x_out, 32'h0, 0);
        check_tol("midrst.y_out", y_out, 32'h0, 0);
        check_tol("midrst.z_out", z_out, 32'h0, 0);
        check_tol("midrst.busy", {31'b0, busy}, 32'h0, 0);
        @(negedge clk);
        check_tol("midrst.done", {31'b0, done}, 32'h0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        issue("post_rst", 1'b0, 32'h0001_0000, 32'h0, 32'h0000_860A, 1'b1,
              32'h0000_DDB4, 32'h0000_8000, 32'h0, 8, 8, 8);
        wait_drain("post_rst");
        repeat (25) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
